// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive-Euclid GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } gcd_state_e;

  // Value the result and operand registers hold after reset or abort.
  localparam int unsigned ZeroResult = 0;

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine; iter_cnt exists only with GCD_ITER_CNT_EN.
interface gcd_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);

  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_err;
`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] iter_cnt;
`endif

  modport master (
    output abort, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, zero_err
`ifdef GCD_ITER_CNT_EN
    , input iter_cnt
`endif
  );

  modport slave (
    input  abort, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, result, zero_err
`ifdef GCD_ITER_CNT_EN
    , output iter_cnt
`endif
  );

endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, magnitude comparator and one shared larger-minus-smaller subtractor.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             sub_a_i,
  input  logic             sub_b_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] minuend, subtrahend, diff;
  logic             gt;

  assign gt = (a_q > b_q);

  // Operands are steered so the single subtractor never underflows.
  assign minuend    = gt ? a_q : b_q;
  assign subtrahend = gt ? b_q : a_q;
  assign diff       = minuend - subtrahend;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (clr_i) begin
      a_d = WIDTH'(ZeroResult);
      b_d = WIDTH'(ZeroResult);
    end else if (load_i) begin
      a_d = a_i;
      b_d = b_i;
    end else if (sub_a_i) begin
      a_d = diff;
    end else if (sub_b_i) begin
      b_d = diff;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= WIDTH'(ZeroResult);
      b_q <= WIDTH'(ZeroResult);
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a_o  = a_q;
  assign b_o  = b_q;
  assign gt_o = gt;
  assign eq_o = (a_q == b_q);
  assign lt_o = (a_q < b_q);

endmodule

// File: rtl/gcd_engine.sv
// Valid/ready GCD engine: FSM, handshakes and (with GCD_ITER_CNT_EN) a saturating iteration counter.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gcd_engine_if.slave  bus
);

  gcd_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_err_q;
  logic             out_valid_q;
`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] cnt_q;
`endif

  logic             in_ready;
  logic             accept;
  logic             calc;
  logic [WIDTH-1:0] a_val, b_val;
  logic             gt, eq, lt;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_ready && bus.in_valid && !bus.abort;
  assign calc     = (state_q == StCalc) && !bus.abort;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (bus.abort),
    .load_i  (accept),
    .sub_a_i (calc && gt),
    .sub_b_i (calc && lt),
    .a_i     (bus.a_in),
    .b_i     (bus.b_in),
    .a_o     (a_val),
    .b_o     (b_val),
    .gt_o    (gt),
    .eq_o    (eq),
    .lt_o    (lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      result_q    <= WIDTH'(ZeroResult);
      zero_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      cnt_q       <= '0;
`endif
    end else if (bus.abort) begin
      state_q     <= StIdle;
      result_q    <= WIDTH'(ZeroResult);
      zero_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
`ifdef GCD_ITER_CNT_EN
            cnt_q <= '0;
`endif
            if (bus.a_in == '0 || bus.b_in == '0) begin
              // A zero operand makes the other one the GCD; no iteration needed.
              result_q    <= bus.a_in | bus.b_in;
              zero_err_q  <= (bus.a_in == '0) && (bus.b_in == '0);
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (eq) begin
            result_q    <= a_val;
            zero_err_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
`ifdef GCD_ITER_CNT_EN
          else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero_err  = zero_err_q;
`ifdef GCD_ITER_CNT_EN
  assign bus.iter_cnt  = cnt_q;
`endif

  // b_val only feeds the comparator inside the datapath; keep it observable for debug.
  logic unused_b;
  assign unused_b = ^b_val;

endmodule
